// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM state encoding and default operand width for the RSA job arbiter
package rsa_pkg;
  localparam int DEF_WIDTH = 4096;
  typedef enum logic [2:0] {IDLE, GRANT, RUN, RESP, GAP} state_t;
endpackage

// File: rtl/rsa_job_arbiter_if.sv
// rsa_job_arbiter_if: requester and exponentiation-engine signals of the RSA job arbiter
interface rsa_job_arbiter_if import rsa_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*WIDTH-1:0] req_message, req_exponent, req_modulus;
  logic [WIDTH-1:0]      rsp_data, eng_message, eng_exponent, eng_modulus, eng_cypher;
  logic                  rsp_err, eng_go, eng_done, eng_rst;
  modport slave (
    input  req_valid, req_message, req_exponent, req_modulus, rsp_ready, eng_cypher, eng_done,
    output req_ready, rsp_valid, rsp_data, rsp_err, eng_go, eng_message, eng_exponent, eng_modulus, eng_rst
  );
  modport master (
    output req_valid, req_message, req_exponent, req_modulus, rsp_ready, eng_cypher, eng_done,
    input  req_ready, rsp_valid, rsp_data, rsp_err, eng_go, eng_message, eng_exponent, eng_modulus, eng_rst
  );
endinterface

// File: rtl/rsa_rr_arbiter.sv
// rsa_rr_arbiter: round-robin pick of the first requester after the last granted one
module rsa_rr_arbiter import rsa_pkg::*; #(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] c;
  // scan downward so the candidate closest after ptr is the one left standing
  always_comb begin
    gnt = '0;
    idx = '0;
    c = '0;
    for (int k = NREQ; k >= 1; k--) begin
      c = IW'((int'(ptr) + k) % NREQ);
      idx = req[c] ? c : idx;
    end
    gnt[idx] = |req;
  end
endmodule

// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: round-robin job arbiter for one RSA engine; RSA_ARB_TIMEOUT_EN adds a RUN watchdog
module rsa_job_arbiter import rsa_pkg::*; #(
  parameter int          WIDTH          = DEF_WIDTH,
  parameter int          NREQ           = 2,
  parameter int          GAP_CYCLES     = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
) (
  input logic clk,
  input logic reset,
  rsa_job_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_t          st, nxt;
  logic [IW-1:0]   last_grant, win, rr_idx;
  logic [NREQ-1:0] rr_gnt;
  logic [WIDTH-1:0] mod_in;
  logic [3:0]      gcnt;
  logic            to, done;
  if (NREQ < 2 || NREQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 15 || TIMEOUT_CYCLES == 32'd0) begin : g_bad_param
    $error("rsa_job_arbiter: parameter out of range");
  end
  rsa_rr_arbiter #(.NREQ(NREQ)) u_rr (.req(bus.req_valid), .ptr(last_grant), .gnt(rr_gnt), .idx(rr_idx));
  assign mod_in        = bus.req_modulus[win*WIDTH +: WIDTH];
  assign done          = (st == RUN) && bus.eng_done;
  assign bus.req_ready = (st == GRANT) ? NREQ'(1) << win : '0;
  assign bus.rsp_valid = (st == RESP) ? NREQ'(1) << win : '0;
  assign bus.eng_go    = (st == RUN);
`ifdef RSA_ARB_TIMEOUT_EN
  logic [31:0] tcnt;
  logic        rst_q;
  assign to          = (st == RUN) && (tcnt == TIMEOUT_CYCLES - 32'd1);
  assign bus.eng_rst = rst_q;
  // count RUN cycles; the engine reset pulse lands on the first RESP cycle after a watchdog expiry
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tcnt <= '0;
      rst_q <= 1'b0;
    end else begin
      tcnt <= (st == RUN) ? tcnt + 32'd1 : '0;
      rst_q <= to && !bus.eng_done;
    end
`else
  assign to          = 1'b0;
  assign bus.eng_rst = 1'b0;
`endif
  // next-state: a job is granted, run (or rejected), answered, then followed by an idle gap
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = |rr_gnt ? GRANT : IDLE;
      GRANT:   nxt = mod_in[0] ? RUN : RESP;
      RUN:     nxt = (bus.eng_done || to) ? RESP : RUN;
      RESP:    nxt = bus.rsp_ready[win] ? GAP : RESP;
      GAP:     nxt = (gcnt == 4'(GAP_CYCLES - 1)) ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  // state, grant pointer, engine operands and the held response
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      last_grant <= IW'(NREQ - 1);
      win <= '0;
      gcnt <= '0;
      bus.eng_message <= '0;
      bus.eng_exponent <= '0;
      bus.eng_modulus <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      st <= nxt;
      gcnt <= (st == GAP) ? gcnt + 4'd1 : '0;
      if (st == IDLE) win <= rr_idx;
      if (st == GRANT) begin
        last_grant <= win;
        bus.eng_message <= bus.req_message[win*WIDTH +: WIDTH];
        bus.eng_exponent <= bus.req_exponent[win*WIDTH +: WIDTH];
        bus.eng_modulus <= mod_in;
      end
      if (((st == GRANT) && !mod_in[0]) || done || to) begin
        bus.rsp_data <= done ? bus.eng_cypher : '0;
        bus.rsp_err <= !done;
      end
    end
endmodule

// File: tb/tb_rsa_job_arbiter.sv
// tb_rsa_job_arbiter: scoreboard bench for rsa_job_arbiter with a modexp engine stub
module tb_rsa_job_arbiter;
  localparam int W = 16, N = 2, GAP = 2;
  typedef struct {int idx; logic [W-1:0] d; logic e;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, eng_en = 1'b1, go_d = 1'b0;
  int n_cmp = 0, n_bad = 0, ecnt = 0, go_hi = 0, low_run = 0, last_gap = 0, run_len = 0, rst_seen = 0;
  exp_t q[$];
  exp_t x;
  always #5 clk = ~clk;
  rsa_job_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
  rsa_job_arbiter #(.WIDTH(W), .NREQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] modexp(logic [W-1:0] m, logic [W-1:0] e, logic [W-1:0] n);
    longint r = 1;
    longint b = longint'(m) % longint'(n);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = r * b % longint'(n);
      b = b * b % longint'(n);
    end
    return W'(r);
  endfunction

  // engine stub: done one cycle after three go-high cycles, gated by eng_en
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ecnt <= 0;
      bus.eng_done <= 1'b0;
      bus.eng_cypher <= '0;
    end else begin
      bus.eng_done <= 1'b0;
      if (bus.eng_go && !bus.eng_done && eng_en) begin
        ecnt <= ecnt + 1;
        if (ecnt == 2) begin
          ecnt <= 0;
          bus.eng_done <= 1'b1;
          bus.eng_cypher <= modexp(bus.eng_message, bus.eng_exponent, bus.eng_modulus);
        end
      end else ecnt <= 0;
    end

  // monitor: go statistics, watchdog pulse timing, and scoreboard on every response transfer
  always @(negedge clk)
    if (rst_n) begin
      if (bus.eng_go) begin
        go_hi++;
        if (!go_d) begin
          last_gap = low_run;
          run_len = 0;
        end
        run_len++;
        low_run = 0;
      end else low_run++;
      go_d = bus.eng_go;
      if (bus.eng_rst) begin
        rst_seen++;
        chk("timeout_run_cycles", run_len, 100);
        chk("timeout_go_low", bus.eng_go, 0);
      end
      if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got rsp_valid %b expected none", bus.rsp_valid);
        end else begin
          x = q.pop_front();
          chk("rsp_valid", bus.rsp_valid, 1 << x.idx);
          chk("rsp_data", bus.rsp_data, x.d);
          chk("rsp_err", bus.rsp_err, x.e);
        end
      end
    end

  task automatic expect_rsp(int i, logic [W-1:0] d, logic e);
    exp_t t;
    t.idx = i;
    t.d = d;
    t.e = e;
    q.push_back(t);
  endtask

  task automatic submit(int i, logic [W-1:0] m, logic [W-1:0] e, logic [W-1:0] n);
    bus.req_message[i*W +: W] = m;
    bus.req_exponent[i*W +: W] = e;
    bus.req_modulus[i*W +: W] = n;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_ready(int i);
    int k = 0;
    while (!bus.req_ready[i] && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("req_ready%0d", i), bus.req_ready, 1 << i);
    bus.req_valid[i] = 1'b0;
    @(negedge clk);
    chk("req_ready_pulse", bus.req_ready, 0);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("drain_queue", q.size(), 0);
  endtask

  initial begin
    int g0, k;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    bus.req_message = '0;
    bus.req_exponent = '0;
    bus.req_modulus = '0;
    submit(0, 8, 13, 77);
    submit(1, 50, 37, 77);
    expect_rsp(0, 50, 0);
    expect_rsp(1, 8, 0);
    repeat (2) @(negedge clk);
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_eng_go", bus.eng_go, 0);
    chk("reset_eng_rst", bus.eng_rst, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_eng_modulus", bus.eng_modulus, 0);
    rst_n = 1'b1;
    wait_ready(0);
    wait_ready(1);
    drain();
    chk("gap_low_cycles", last_gap, 3 + GAP);
    expect_rsp(0, 50, 0);
    submit(0, 8, 13, 77);
    wait_ready(0);
    chk("eng_message", bus.eng_message, 8);
    chk("eng_modulus", bus.eng_modulus, 77);
    drain();
    g0 = go_hi;
    expect_rsp(1, 0, 1);
    submit(1, 8, 13, 76);
    wait_ready(1);
    drain();
    chk("even_no_go", go_hi - g0, 0);
    bus.rsp_ready = '0;
    expect_rsp(0, 8, 0);
    expect_rsp(1, 50, 0);
    submit(0, 50, 37, 77);
    wait_ready(0);
    submit(1, 8, 13, 77);
    k = 0;
    while (!bus.rsp_valid[0] && k < 100) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_data", bus.rsp_data, 8);
      chk("hold_no_grant", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = '1;
    wait_ready(1);
    drain();
    eng_en = 1'b0;
    submit(0, 8, 13, 77);
    wait_ready(0);
    repeat (3) @(negedge clk);
    chk("run_go_high", bus.eng_go, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_go_low", bus.eng_go, 0);
    chk("reset_mid_rsp_valid", bus.rsp_valid, 0);
    chk("reset_mid_operands", bus.eng_modulus, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abandoned_no_rsp", bus.rsp_valid, 0);
    eng_en = 1'b1;
    expect_rsp(0, 50, 0);
    submit(0, 8, 13, 77);
    wait_ready(0);
    drain();
`ifdef RSA_ARB_TIMEOUT_EN
    eng_en = 1'b0;
    expect_rsp(1, 0, 1);
    submit(1, 8, 13, 77);
    wait_ready(1);
    drain();
    chk("timeout_rst_pulses", rst_seen, 1);
    eng_en = 1'b1;
`endif
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rsa_job_arbiter.md
RSA_JOB_ARBITER -- requirements
Module: rsa_job_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4096: operand and result width in bits.
REQ-002 SHALL have parameter NREQ, default 2: number of requesters (2..8).
REQ-003 SHALL have parameter GAP_CYCLES, default 2: engine idle cycles (go low) between jobs (1..15).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 32'd2000000: watchdog limit, used only under RSA_ARB_TIMEOUT_EN.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  NREQ  per-requester job request.
REQ-008 req_ready  out  NREQ  one-hot acceptance pulse.
REQ-009 req_message, req_exponent, req_modulus  in  NREQ*WIDTH each  flattened operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-010 rsp_valid  out  NREQ  one-hot result valid, addressed to the owning requester.
REQ-011 rsp_ready  in  NREQ  per-requester result acceptance.
REQ-012 rsp_data  out  WIDTH  result; rsp_err  out  1  job failed.
REQ-013 eng_go  out  1; eng_message, eng_exponent, eng_modulus  out  WIDTH; eng_cypher  in  WIDTH; eng_done  in  1  (exponentiation engine port).
REQ-014 eng_rst  out  1  active-high engine reset pulse.

Function
REQ-015 SHALL implement states IDLE, GRANT, RUN, RESP, GAP.
REQ-016 IDLE: if any req_valid, select winner by round-robin starting at (last_grant+1) mod NREQ, then go to GRANT; otherwise stay in IDLE.
REQ-017 GRANT (1 cycle): latch winner operands into eng_* registers, pulse req_ready[winner] for exactly this cycle.
REQ-018 GRANT: even modulus (bit 0 = 0) -> skip engine, rsp_data=0, rsp_err=1, go to RESP.
REQ-019 GRANT, odd modulus -> RUN; eng_go=1 from first RUN cycle, held high until eng_done sampled high.
REQ-020 RUN: eng_done=1 -> capture eng_cypher into rsp_data, rsp_err=0, eng_go=0 next cycle, go to RESP.
REQ-021 RESP: rsp_valid[winner]=1, rsp_data/rsp_err stable until rsp_ready[winner]=1; then go to GAP.
REQ-022 GAP: eng_go=0 for exactly GAP_CYCLES cycles, then IDLE; no grant during GAP.
REQ-023 Requester-to-next-grant latency: minimum 1 cycle IDLE + 1 GRANT; throughput one job per engine run + RESP + GAP.
REQ-024 req_valid changes or new requests while busy SHALL be ignored until the next IDLE.
REQ-025 Round-robin pointer SHALL wrap from NREQ-1 to 0; pointer updates only in GRANT.
REQ-026 eng_message/exponent/modulus SHALL remain constant from GRANT through end of GAP.
REQ-027 rsp_valid deasserting of an unready requester SHALL never occur (no drop).

Reset
REQ-028 On reset low: state=IDLE, last_grant=NREQ-1 (first grant to requester 0), req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, eng_go=0, eng_* operands=0, eng_rst=0, counters=0.
REQ-029 Reset asserted mid-job SHALL abandon the job with no response; engine sees eng_go=0 immediately.

Configuration
REQ-030 Macro RSA_ARB_TIMEOUT_EN defined: RUN cycle counter; reaching TIMEOUT_CYCLES without eng_done -> eng_go=0, eng_rst=1 for one cycle, rsp_data=0, rsp_err=1, go to RESP.
REQ-031 Macro undefined: no counter, eng_rst tied 0, RUN waits indefinitely.

Structure
REQ-032 Shared package rsa_pkg SHALL hold the state encoding enum and default WIDTH constant (4096).
REQ-033 Round-robin selection SHALL be sub-module rsa_rr_arbiter (request vector + pointer -> one-hot grant, grant index).

Verification
REQ-034 Single job, requester 0: message 8, exponent 13, modulus 77 -> rsp_valid[0], rsp_data=50, rsp_err=0.
REQ-035 Both requesters valid from reset: req0 (8,13,77), req1 (50,37,77) -> req0 served first (50), then req1 (8); eng_go low GAP_CYCLES between runs.
REQ-036 Requester 1 submits modulus 76 -> no eng_go, rsp_valid[1] with rsp_err=1, rsp_data=0.
REQ-037 rsp_ready[0] held low 20 cycles -> rsp_valid[0] and rsp_data held stable, no new grant during hold.
REQ-038 With RSA_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, engine stub never asserts done -> eng_rst pulse at RUN cycle 100, rsp_err=1.
REQ-039 Reset pulled low during RUN -> eng_go=0 asynchronously, no rsp_valid, next job served normally.
